// File: rtl/pixel_byte_packer.sv
// pixel_byte_packer
// Packs one-pixel-per-clock serial video into bytes. Each byte is tagged with
// start-of-frame and end-of-line flags and buffered in a small FIFO behind a
// valid/ready handshake. Wrong line lengths and FIFO overflow raise sticky flags.
// Build option: define PACKER_LSB_FIRST_EN for LSB-first bit order.
// The default build packs MSB-first.
module pixel_byte_packer #(
  parameter int unsigned IMG_WIDTH  = 41,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_in,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_sof,
  output logic       out_eol,
  output logic [7:0] row_count,
  output logic       line_err,
  output logic       ovf_err
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  WIDTH_C  = 8'(IMG_WIDTH);
  localparam logic [7:0]  LAST_COL = 8'(IMG_WIDTH - 1);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    RUN,
    OVERRUN
  } state_t;

  // Framing / packing state
  state_t     r_state;
  logic [7:0] r_col;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_sof_pend;
  logic       r_first_hs;
  logic [7:0] r_row_count;
  logic       r_line_err;
  logic       r_ovf_err;

  // FIFO storage: {sof, eol, byte}
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic       w_capture;
  logic       w_hs_restart;
  logic [7:0] w_col;
  logic [2:0] w_bit;
  logic [7:0] w_shift;
  logic [7:0] w_mask;
  logic [7:0] w_byte;
  logic       w_eol;
  logic       w_sof;
  logic       w_byte_done;
  logic       w_pop;
  logic       w_full;
  logic       w_push;
  logic       w_drop;
  logic [9:0] w_head;

  // Decide whether this cycle's pixel is captured, and at which column/bit.
  // A line start (v_sync, or h_sync while framed) discards any partial byte.
  always_comb begin
    w_capture    = 1'b0;
    w_hs_restart = 1'b0;
    w_col        = r_col;
    w_bit        = r_bit_cnt;
    w_shift      = r_shift;
    if (v_sync) begin
      w_capture = 1'b1;
      w_col     = '0;
      w_bit     = '0;
      w_shift   = '0;
    end else if (r_state != WAIT_FRAME && h_sync) begin
      w_capture    = 1'b1;
      w_hs_restart = 1'b1;
      w_col        = '0;
      w_bit        = '0;
      w_shift      = '0;
    end else if (r_state == RUN && r_col != WIDTH_C) begin
      w_capture = 1'b1;
    end
  end

`ifdef PACKER_LSB_FIRST_EN
  assign w_mask = 8'h01 << w_bit;
`else
  assign w_mask = 8'h80 >> w_bit;
`endif

  assign w_byte      = pix_in ? (w_shift | w_mask) : w_shift;
  assign w_eol       = (w_col == LAST_COL);
  assign w_byte_done = w_capture && ((w_bit == 3'd7) || w_eol);
  assign w_sof       = v_sync | r_sof_pend;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign w_pop  = out_valid & out_ready;
  assign w_full = (r_count == DEPTH_C);
  assign w_push = w_byte_done & (~w_full | w_pop);
  assign w_drop = w_byte_done & w_full & ~w_pop;

  // Framing FSM, column/bit counters, shift register, row count and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= WAIT_FRAME;
      r_col       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_sof_pend  <= 1'b0;
      r_first_hs  <= 1'b0;
      r_row_count <= '0;
      r_line_err  <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      // A v_sync that also carries h_sync has already consumed the
      // "first h_sync" grace.
      if (v_sync) begin
        r_state    <= RUN;
        r_first_hs <= ~h_sync;
      end else if (w_hs_restart) begin
        r_state    <= RUN;
        r_first_hs <= 1'b0;
        if (!r_first_hs && (r_state == OVERRUN || r_col != WIDTH_C)) begin
          r_line_err <= 1'b1;
        end
      end else if (r_state == RUN && r_col == WIDTH_C) begin
        r_state <= OVERRUN;
      end

      if (w_capture) begin
        r_col <= w_col + 8'd1;
        if (w_byte_done) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= w_byte;
          r_bit_cnt <= w_bit + 3'd1;
        end
      end

      if (w_byte_done) begin
        r_sof_pend <= 1'b0;
      end else if (v_sync) begin
        r_sof_pend <= 1'b1;
      end

      if (v_sync) begin
        r_row_count <= (w_push && w_eol) ? 8'd1 : 8'd0;
      end else if (w_push && w_eol) begin
        r_row_count <= r_row_count + 8'd1;
      end

      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_sof, w_eol, w_byte};
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_byte  = out_valid ? w_head[7:0] : '0;
  assign out_eol   = out_valid ? w_head[8] : 1'b0;
  assign out_sof   = out_valid ? w_head[9] : 1'b0;
  assign row_count = r_row_count;
  assign line_err  = r_line_err;
  assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_pixel_byte_packer.sv
// Randomized self-checking bench for pixel_byte_packer.
// A line-level reference model keeps the pixels of the current line and an
// expected FIFO queue.
module tb_pixel_byte_packer;

  localparam int W = 41;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_in;
  logic       h_sync;
  logic       v_sync;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_sof;
  logic       out_eol;
  logic [7:0] row_count;
  logic       line_err;
  logic       ovf_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. m_mode: 0 = waiting for frame, 1 = capturing,
  // 2 = line overran.
  int         m_mode;
  bit         m_first;
  bit         m_sofp;
  bit         m_lerr;
  bit         m_ovf;
  int         m_row;
  bit         m_line[$];
  logic [9:0] m_q[$];

  pixel_byte_packer #(.IMG_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .row_count (row_count),
    .line_err  (line_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Builds a byte from n pixels of the current line, starting at column 'first'.
  function automatic logic [7:0] pack_bits(input int first, input int n);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < n; k++) begin
      if (m_line[first + k]) begin
`ifdef PACKER_LSB_FIRST_EN
        b[k] = 1'b1;
`else
        b[7 - k] = 1'b1;
`endif
      end
    end
    return b;
  endfunction

  task automatic model_step(input bit r, input bit p, input bit hs, input bit vs, input bit rdy);
    bit cap;
    bit pop;
    cap = 1'b0;
    if (r) begin
      m_mode  = 0;
      m_first = 0;
      m_sofp  = 0;
      m_lerr  = 0;
      m_ovf   = 0;
      m_row   = 0;
      m_line.delete();
      m_q.delete();
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (vs) begin
      m_mode  = 1;
      m_first = !hs;
      m_sofp  = 1;
      m_row   = 0;
      m_line.delete();
      cap = 1'b1;
    end else if (m_mode != 0 && hs) begin
      if (!m_first && (m_mode == 2 || m_line.size() != W)) m_lerr = 1;
      m_first = 0;
      m_mode  = 1;
      m_line.delete();
      cap = 1'b1;
    end else if (m_mode == 1) begin
      if (m_line.size() == W) m_mode = 2;
      else cap = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      int c;
      m_line.push_back(p);
      c = m_line.size() - 1;
      if ((c % 8 == 7) || (c == W - 1)) begin
        bit eol;
        int n;
        eol = (c == W - 1);
        n   = c % 8 + 1;
        if (m_q.size() < D) begin
          m_q.push_back({m_sofp, eol, pack_bits(c - n + 1, n)});
          if (eol) m_row = (m_row + 1) % 256;
        end else begin
          m_ovf = 1;
        end
        m_sofp = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_eq("out_byte", out_byte, m_q[0][7:0]);
      check_eq("out_sof", out_sof, m_q[0][9]);
      check_eq("out_eol", out_eol, m_q[0][8]);
    end
    check_eq("row_count", row_count, m_row);
    check_eq("line_err", line_err, m_lerr);
    check_eq("ovf_err", ovf_err, m_ovf);
  endtask

  // Called at a falling edge: check, drive, advance model, wait one cycle.
  task automatic cycle(input bit r, input bit p, input bit hs, input bit vs, input bit rdy);
    check_outputs();
    reset     = r;
    pix_in    = p;
    h_sync    = hs;
    v_sync    = vs;
    out_ready = rdy;
    model_step(r, p, hs, vs, rdy);
    @(negedge clk);
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return (mode != 0);
  endfunction

  // pmode: 0 all ones, 1 alternating 1,0, 2 random. rmode: 0 stall, 1 ready, 2 random.
  task automatic send_line(input int n, input bit vs, input int pmode, input int rmode);
    bit p;
    for (int i = 0; i < n; i++) begin
      if (pmode == 0) p = 1'b1;
      else if (pmode == 1) p = (i % 2 == 0);
      else p = bit'($urandom_range(0, 1));
      cycle(1'b0, p, i == 0, vs && (i == 0), pick_rdy(rmode));
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) cycle(1'b0, bit'($urandom_range(0, 1)), 1'b0, 1'b0, pick_rdy(rmode));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
  endtask

  initial begin
    reset     = 1'b1;
    pix_in    = 1'b0;
    h_sync    = 1'b0;
    v_sync    = 1'b0;
    out_ready = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_byte", out_byte, 8'h00);
    check_eq("rst_out_sof", out_sof, 1'b0);
    check_eq("rst_out_eol", out_eol, 1'b0);

    // Pixels before any frame start, then a full line of ones and a random line.
    idle(10, 2);
    send_line(W, 1'b1, 0, 1);
    send_line(W, 1'b0, 2, 1);
    idle(6, 1);
    do_reset(2);

    // Frame start with an alternating pattern.
    idle(7, 1);
    send_line(W, 1'b1, 1, 1);
    send_line(W, 1'b0, 0, 1);
    idle(6, 1);
    do_reset(2);

    // Sink stalled for a whole line, then released.
    send_line(W, 1'b1, 0, 0);
    idle(10, 1);
    do_reset(2);

    // Truncated line followed by normal lines.
    send_line(W, 1'b1, 0, 1);
    send_line(20, 1'b0, 0, 1);
    send_line(W, 1'b0, 0, 1);
    send_line(W, 1'b0, 2, 1);
    idle(6, 1);
    do_reset(2);

    // Overlong line.
    send_line(W, 1'b1, 0, 1);
    send_line(W + 4, 1'b0, 2, 1);
    send_line(W, 1'b0, 0, 1);
    idle(6, 1);
    do_reset(2);

    // Randomized traffic with mid-frame v_sync, odd line lengths and a mid-line reset.
    send_line(W, 1'b1, 2, 2);
    for (int it = 0; it < 300; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: send_line(W, 1'b0, 2, 2);
        5:             send_line($urandom_range(1, W - 1), 1'b0, 2, 2);
        6:             send_line(W + $urandom_range(1, 6), 1'b0, 2, 2);
        7:             send_line(W, 1'b1, 2, 2);
        8:             send_line(W, 1'b0, 2, 0);
        default: begin
          idle($urandom_range(1, 5), 1);
          send_line(W, 1'b0, 2, 1);
        end
      endcase
      if (it == 150) begin
        send_line(17, 1'b0, 2, 2);
        do_reset(1);
      end
    end
    idle(8, 1);
    do_reset(2);

    // Long frame so row_count wraps past 255.
    send_line(W, 1'b1, 2, 1);
    for (int ln = 0; ln < 259; ln++) send_line(W, 1'b0, 2, 1);
    idle(8, 1);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
